gear_indicator_monitor: RTL

GEAR_INDICATOR_MONITOR -- requirements
Module: gear_indicator_monitor

---
 rtl/gear_indicator_monitor_if.sv | 44 ++++
 rtl/gear_indicator_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gear_indicator_monitor_if.sv
// Gear indicator monitor bus: indicator input, event handshake, status and
// sticky error flags. The shift_cnt signal exists only when SHIFT_COUNTER_EN
// is defined.
//   master : environment side (drives ind, clr, evt_ready)
//   slave  : monitor side (drives gear, event and error outputs)
interface gear_indicator_monitor_if;
  logic [6:0] ind;          // {R1,N1,P1,D4,D3,D2,D1}
  logic       clr;
  logic       evt_ready;
  logic [2:0] gear;
  logic       gear_valid;
  logic       evt_valid;
  logic [2:0] evt_from;
  logic [2:0] evt_to;
  logic       err_illegal;
  logic       err_overrun;
`ifdef SHIFT_COUNTER_EN
  logic [7:0] shift_cnt;

  modport master (
    output ind, clr, evt_ready,
    input  gear, gear_valid, evt_valid, evt_from, evt_to,
    input  err_illegal, err_overrun, shift_cnt
  );

  modport slave (
    input  ind, clr, evt_ready,
    output gear, gear_valid, evt_valid, evt_from, evt_to,
    output err_illegal, err_overrun, shift_cnt
  );
`else
  modport master (
    output ind, clr, evt_ready,
    input  gear, gear_valid, evt_valid, evt_from, evt_to,
    input  err_illegal, err_overrun
  );

  modport slave (
    input  ind, clr, evt_ready,
    output gear, gear_valid, evt_valid, evt_from, evt_to,
    output err_illegal, err_overrun
  );
`endif
endinterface

// File: rtl/gear_indicator_monitor.sv
// Gear indicator monitor: debounces the 7-bit indicator bus, decodes the
// accepted pattern into a gear code, reports gear changes through a one-deep
// valid/ready event slot and keeps sticky illegal/overrun flags.
// Optional feature: define SHIFT_COUNTER_EN to build the 8-bit wrapping
// shift_cnt counter of accepted gear changes.
module gear_indicator_monitor #(
  parameter int unsigned STABLE_CYCLES = 4  // 2..15
) (
  input  logic                     clk,
  input  logic                     rst,
  gear_indicator_monitor_if.slave  bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Returns {legal, code}; anything outside the table is illegal with code 0.
  function automatic logic [3:0] decode_ind(input logic [6:0] pat);
    logic [3:0] res;
    case (pat)
      7'b0010000: res = {1'b1, 3'd1};  // P
      7'b1000000: res = {1'b1, 3'd2};  // R
      7'b0100000: res = {1'b1, 3'd3};  // N
      7'b0000001: res = {1'b1, 3'd4};  // D1
      7'b0000011: res = {1'b1, 3'd5};  // D2
      7'b0000111: res = {1'b1, 3'd6};  // D3
      7'b0001111: res = {1'b1, 3'd7};  // D4
      default:    res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  logic [6:0] sample_r;
  logic [3:0] stab_cnt_r;
  logic [3:0] stab_cnt_nxt_s;
  logic       accept_r;
  logic [3:0] dec_s;
  logic       legal_s;
  logic [2:0] code_s;
  logic       change_s;
  logic       illegal_set_s;
  logic       overrun_set_s;
  logic       hs_s;
  state_t     state_r;
  logic [2:0] gear_r;
  logic       gear_valid_r;
  logic       evt_valid_r;
  logic [2:0] evt_from_r;
  logic [2:0] evt_to_r;
  logic       err_illegal_r;
  logic       err_overrun_r;

  // Next stability count: restart on a new sample, otherwise count up and saturate
  always_comb begin
    stab_cnt_nxt_s = stab_cnt_r;
    if (bus.ind != sample_r) begin
      stab_cnt_nxt_s = 4'd1;
    end else if (stab_cnt_r < STABLE_C) begin
      stab_cnt_nxt_s = stab_cnt_r + 4'd1;
    end else begin
      stab_cnt_nxt_s = stab_cnt_r;
    end
  end

  // Register the indicator bus, its stability count and the one-shot accept strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r   <= 7'd0;
      stab_cnt_r <= 4'd0;
      accept_r   <= 1'b0;
    end else begin
      sample_r   <= bus.ind;
      stab_cnt_r <= stab_cnt_nxt_s;
      accept_r   <= (stab_cnt_nxt_s == STABLE_C) && (stab_cnt_r != STABLE_C);
    end
  end

  // Decode the held sample and derive the change / error / handshake strobes
  always_comb begin
    dec_s         = decode_ind(sample_r);
    legal_s       = dec_s[3];
    code_s        = dec_s[2:0];
    hs_s          = evt_valid_r & bus.evt_ready;
    change_s      = accept_r & legal_s & (code_s != gear_r);
    illegal_set_s = accept_r & ~legal_s;
    overrun_set_s = change_s & (state_r == PEND) & ~hs_s;
  end

  // Track the current gear and whether the accepted pattern is legal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gear_r       <= 3'd0;
      gear_valid_r <= 1'b0;
    end else if (accept_r) begin
      if (legal_s) begin
        gear_valid_r <= 1'b1;
        gear_r       <= code_s;
      end else begin
        gear_valid_r <= 1'b0;
      end
    end
  end

  // Sticky error flags: a set in the same cycle as clr takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      if (illegal_set_s) begin
        err_illegal_r <= 1'b1;
      end else if (bus.clr) begin
        err_illegal_r <= 1'b0;
      end
      if (overrun_set_s) begin
        err_overrun_r <= 1'b1;
      end else if (bus.clr) begin
        err_overrun_r <= 1'b0;
      end
    end
  end

  // Event slot FSM: load on change, hold while pending, release on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      evt_valid_r <= 1'b0;
      evt_from_r  <= 3'd0;
      evt_to_r    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (change_s) begin
            evt_from_r  <= gear_r;
            evt_to_r    <= code_s;
            evt_valid_r <= 1'b1;
            state_r     <= PEND;
          end
        end
        PEND: begin
          if (change_s && hs_s) begin
            // Slot frees and refills in the same cycle
            evt_from_r  <= gear_r;
            evt_to_r    <= code_s;
            evt_valid_r <= 1'b1;
          end else if (hs_s) begin
            evt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          evt_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_COUNTER_EN
  logic [7:0] shift_cnt_r;

  // Count accepted gear changes, wrapping at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt_r <= 8'd0;
    end else if (change_s) begin
      shift_cnt_r <= shift_cnt_r + 8'd1;
    end
  end

  assign bus.shift_cnt = shift_cnt_r;
`endif

  assign bus.gear        = gear_r;
  assign bus.gear_valid  = gear_valid_r;
  assign bus.evt_valid   = evt_valid_r;
  assign bus.evt_from    = evt_from_r;
  assign bus.evt_to      = evt_to_r;
  assign bus.err_illegal = err_illegal_r;
  assign bus.err_overrun = err_overrun_r;

endmodule
